// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encodings,
// digit count, 7-segment lookup and the BCD increment helper.
package stopwatch_pkg;

   localparam int NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   // Segment patterns for digits 0..9; entry 0 sits in the low bits.
   localparam logic [9:0][6:0] SEG_LUT = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      return (digit < 4'd10) ? SEG_LUT[digit] : 7'h00;
   endfunction

   // Returns {carry_out, incremented value}; carry_out marks the 9999 -> 0000 wrap.
   function automatic logic [4*NUM_DIGITS:0] bcd_inc(input logic [4*NUM_DIGITS-1:0] val);
      logic [4*NUM_DIGITS:0] res;
      logic                  carry;
      res   = '0;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry && (val[4*i +: 4] == 4'd9)) begin
            res[4*i +: 4] = 4'd0;
         end else begin
            res[4*i +: 4] = val[4*i +: 4] + {3'b000, carry};
            carry         = 1'b0;
         end
      end
      res[4*NUM_DIGITS] = carry;
      return res;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, debounce filter and press pulse.
// Ports:
//   clk, rst  - system clock, async active-high reset
//   btn_raw   - raw asynchronous button level
//   press     - one-cycle pulse on each debounced 0->1 transition
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q counts consecutive samples that disagree with the debounced level;
   // any agreeing sample restarts the run.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = level_d & ~level_q;
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller for a 4-digit BCD stopwatch with multiplexed
// 7-segment display.
// Ports:
//   clk, rst                  - system clock, async active-high reset
//   btn_start_stop, btn_clear - raw buttons, active-high
//   seg                       - registered segments, seg[0]=a .. seg[6]=g
//   dig_en                    - registered one-hot digit enable, [0]=LSD
//   count_bcd                 - four BCD digits, [3:0]=LSD
//   running                   - high in RUN
//   overflow                  - sticky, set on 9999 -> 0000 wrap
//
// state | meaning
// IDLE  | count cleared, waiting for start
// RUN   | prescaler and counter advancing
// PAUSE | count and prescaler held
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV         = 1000000,
   parameter int SCAN_DIV        = 1000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    btn_start_stop,
   input  logic                    btn_clear,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic [4*NUM_DIGITS-1:0] count_bcd,
   output logic                    running,
   output logic                    overflow
);

   localparam int            PW         = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam int            SW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam int            IW         = $clog2(NUM_DIGITS);

   logic ss_press, clr_press;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_start_stop),
      .press   (ss_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_clear),
      .press   (clr_press)
   );

   state_e                  state_q, state_d;
   logic [PW-1:0]           presc_q, presc_d;
   logic [4*NUM_DIGITS-1:0] count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic [SW-1:0]           scan_q, scan_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [6:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
   logic [4*NUM_DIGITS:0]   count_inc;
   logic                    tick;

   assign count_inc = bcd_inc(count_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         scan_q   <= '0;
         idx_q    <= '0;
         seg_q    <= '0;
         dig_en_q <= '0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         scan_q   <= scan_d;
         idx_q    <= idx_d;
         seg_q    <= seg_d;
         dig_en_q <= dig_en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      tick    = (state_q == RUN) && (presc_q == PRESC_LAST);

      if (state_q == RUN) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            count_d = count_inc[4*NUM_DIGITS-1:0];
            if (count_inc[4*NUM_DIGITS]) begin
               ovf_d = 1'b1;
            end
         end
      end

      // clr takes priority outside RUN; inside RUN only ss is honoured.
      case (state_q)
         IDLE: begin
            if (clr_press) begin
               count_d = '0;
               ovf_d   = 1'b0;
            end else if (ss_press) begin
               state_d = RUN;
               presc_d = '0;
            end
         end
         RUN: begin
            if (ss_press) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (clr_press) begin
               state_d = IDLE;
               count_d = '0;
               presc_d = '0;
               ovf_d   = 1'b0;
            end else if (ss_press) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      scan_d = scan_q + SW'(1);
      idx_d  = idx_q;
      if (scan_q == SCAN_LAST) begin
         scan_d = '0;
         idx_d  = idx_q + IW'(1);
      end
      dig_en_d = NUM_DIGITS'(1) << idx_q;
      seg_d    = seg_decode(count_q[{idx_q, 2'b00} +: 4]);
   end

   assign seg       = seg_q;
   assign dig_en    = dig_en_q;
   assign count_bcd = count_q;
   assign running   = (state_q == RUN);
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

   localparam int CLK_DIV  = 4;
   localparam int SCAN_DIV = 2;
   localparam int DEB      = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_ss = 1'b0;
   logic        btn_clr = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  dig_en;
   logic [15:0] count_bcd;
   logic        running;
   logic        overflow;

   stopwatch_ctrl #(
      .CLK_DIV         (CLK_DIV),
      .SCAN_DIV        (SCAN_DIV),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .btn_start_stop (btn_ss),
      .btn_clear      (btn_clr),
      .seg            (seg),
      .dig_en         (dig_en),
      .count_bcd      (count_bcd),
      .running        (running),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   typedef enum int {K_COUNT, K_RUN, K_OVF, K_DIG, K_SEG} kind_e;
   typedef struct {
      string       tag;
      kind_e       kind;
      logic [15:0] exp;
   } sb_item_t;

   sb_item_t sb_q[$];
   int       n_checks = 0;
   int       n_errors = 0;
   int       rc;
   logic [6:0] seg_exp [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};

   task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic sb_push(input string tag, input kind_e k, input logic [15:0] e);
      sb_item_t it;
      it.tag  = tag;
      it.kind = k;
      it.exp  = e;
      sb_q.push_back(it);
   endtask

   task automatic sb_drain();
      sb_item_t    it;
      logic [15:0] act;
      while (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         case (it.kind)
            K_COUNT: act = count_bcd;
            K_RUN:   act = {15'd0, running};
            K_OVF:   act = {15'd0, overflow};
            K_DIG:   act = {12'd0, dig_en};
            default: act = {9'd0, seg};
         endcase
         check_val(it.tag, act, it.exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Raw button held 4 cycles; the resulting state is visible 6 cycles after
   // the raw edge, where pending expectations are compared. Callers leave at
   // least 4 more cycles before the next press so the debouncer settles low.
   task automatic press(input logic s, input logic c);
      btn_ss  = s;
      btn_clr = c;
      step(4);
      btn_ss  = 1'b0;
      btn_clr = 1'b0;
      step(2);
      sb_drain();
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      int m;
      m = v % 10000;
      return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   task automatic push_reset_state(input string tag);
      sb_push({tag, ".count"}, K_COUNT, 16'h0000);
      sb_push({tag, ".run"},   K_RUN,   16'd0);
      sb_push({tag, ".ovf"},   K_OVF,   16'd0);
      sb_push({tag, ".dig"},   K_DIG,   16'd0);
      sb_push({tag, ".seg"},   K_SEG,   16'd0);
   endtask

   initial begin : main
      logic [3:0] prev;
      logic       found;
      logic [3:0] de;

      // Reset values and first display after release
      step(3);
      push_reset_state("rst");
      sb_drain();
      rst = 1'b0;
      step(1);
      sb_push("rst.first_dig", K_DIG, 16'h0001);
      sb_push("rst.first_seg", K_SEG, 16'h003F);
      sb_drain();
      step(2);

      // 1: start with ss held 10 cycles
      btn_ss = 1'b1;
      step(5);
      sb_push("t1.run_before", K_RUN, 16'd0);
      sb_drain();
      step(1);
      sb_push("t1.run_enter", K_RUN, 16'd1);
      sb_drain();
      rc = 0;
      step(3);
      sb_push("t1.cnt3", K_COUNT, to_bcd(0));
      sb_drain();
      step(1);
      sb_push("t1.cnt4", K_COUNT, to_bcd(1));
      sb_drain();
      btn_ss = 1'b0;
      step(4);
      rc = 8;
      sb_push("t1.cnt8", K_COUNT, to_bcd(rc / CLK_DIV));
      sb_drain();
      step(7);
      rc = 15;

      // 2: pause, hold, resume from held prescaler
      sb_push("t2.pause_run", K_RUN, 16'd0);
      sb_push("t2.pause_cnt", K_COUNT, to_bcd((rc + 6) / CLK_DIV));
      press(1'b1, 1'b0);
      rc += 6;
      step(40);
      sb_push("t2.frozen_cnt", K_COUNT, to_bcd(rc / CLK_DIV));
      sb_push("t2.frozen_run", K_RUN, 16'd0);
      sb_drain();
      sb_push("t2.resume_run", K_RUN, 16'd1);
      sb_push("t2.resume_cnt", K_COUNT, to_bcd(rc / CLK_DIV));
      press(1'b1, 1'b0);
      step(CLK_DIV - (rc % CLK_DIV) - 1);
      rc += CLK_DIV - (rc % CLK_DIV) - 1;
      sb_push("t2.pre_tick", K_COUNT, to_bcd(rc / CLK_DIV));
      sb_drain();
      step(1);
      rc += 1;
      sb_push("t2.post_tick", K_COUNT, to_bcd(rc / CLK_DIV));
      sb_drain();

      // 4: clr ignored in RUN, honoured in PAUSE
      step(4);
      rc += 4;
      sb_push("t4.clr_run_run", K_RUN, 16'd1);
      sb_push("t4.clr_run_cnt", K_COUNT, to_bcd((rc + 6) / CLK_DIV));
      press(1'b0, 1'b1);
      rc += 6;
      step(4);
      rc += 4;
      sb_push("t4.still_cnt", K_COUNT, to_bcd(rc / CLK_DIV));
      sb_push("t4.still_run", K_RUN, 16'd1);
      sb_drain();
      sb_push("t4.pause_run", K_RUN, 16'd0);
      sb_push("t4.pause_cnt", K_COUNT, to_bcd((rc + 6) / CLK_DIV));
      press(1'b1, 1'b0);
      rc += 6;
      step(4);
      sb_push("t4.clr_cnt", K_COUNT, 16'h0000);
      sb_push("t4.clr_run", K_RUN, 16'd0);
      sb_push("t4.clr_ovf", K_OVF, 16'd0);
      press(1'b0, 1'b1);
      rc = 0;
      step(4);
      sb_push("t4.idle_cnt", K_COUNT, 16'h0000);
      sb_drain();

      // 5: simultaneous ss+clr
      sb_push("t5.start_run", K_RUN, 16'd1);
      press(1'b1, 1'b0);
      rc = 0;
      step(10);
      rc += 10;
      sb_push("t5.both_run_run", K_RUN, 16'd0);
      sb_push("t5.both_run_cnt", K_COUNT, to_bcd((rc + 6) / CLK_DIV));
      press(1'b1, 1'b1);
      rc += 6;
      step(4);
      sb_push("t5.held_cnt", K_COUNT, to_bcd(rc / CLK_DIV));
      sb_drain();
      sb_push("t5.both_pause_run", K_RUN, 16'd0);
      sb_push("t5.both_pause_cnt", K_COUNT, 16'h0000);
      press(1'b1, 1'b1);
      rc = 0;
      step(4);
      sb_push("t5.both_idle_run", K_RUN, 16'd0);
      press(1'b1, 1'b1);
      step(4);

      // 6: display scan at 1234, then a short glitch
      sb_push("t6.start_run", K_RUN, 16'd1);
      press(1'b1, 1'b0);
      rc = 0;
      step(4930);
      rc += 4930;
      sb_push("t6.pause_cnt", K_COUNT, to_bcd((rc + 6) / CLK_DIV));
      sb_push("t6.pause_run", K_RUN, 16'd0);
      press(1'b1, 1'b0);
      rc += 6;
      step(4);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         prev = dig_en;
         step(1);
         if (prev == 4'b1000 && dig_en == 4'b0001) found = 1'b1;
      end
      check_val("t6.scan_sync", {15'd0, found}, 16'd1);
      for (int k = 0; k < 8; k++) begin
         de = 4'b0001 << (k / 2);
         sb_push($sformatf("t6.scan%0d.dig", k), K_DIG, {12'd0, de});
         sb_push($sformatf("t6.scan%0d.seg", k), K_SEG, {9'd0, seg_exp[k / 2]});
         sb_drain();
         step(1);
      end
      btn_ss = 1'b1;
      step(2);
      btn_ss = 1'b0;
      step(10);
      sb_push("t6.glitch_run", K_RUN, 16'd0);
      sb_push("t6.glitch_cnt", K_COUNT, 16'h1234);
      sb_drain();

      // 3: run through the 9999 -> 0000 wrap
      sb_push("t3.resume_run", K_RUN, 16'd1);
      press(1'b1, 1'b0);
      step(39999 - rc);
      rc = 39999;
      sb_push("t3.pre_wrap_cnt", K_COUNT, 16'h9999);
      sb_push("t3.pre_wrap_ovf", K_OVF, 16'd0);
      sb_drain();
      step(1);
      rc += 1;
      sb_push("t3.wrap_cnt", K_COUNT, 16'h0000);
      sb_push("t3.wrap_ovf", K_OVF, 16'd1);
      sb_drain();
      step(8);
      rc += 8;
      sb_push("t3.after_cnt", K_COUNT, to_bcd(rc / CLK_DIV));
      sb_push("t3.after_ovf", K_OVF, 16'd1);
      sb_drain();
      sb_push("t3.clr_run_cnt", K_COUNT, to_bcd((rc + 6) / CLK_DIV));
      sb_push("t3.clr_run_ovf", K_OVF, 16'd1);
      press(1'b0, 1'b1);
      rc += 6;
      step(4);
      rc += 4;
      sb_push("t3.pause_cnt", K_COUNT, to_bcd((rc + 6) / CLK_DIV));
      sb_push("t3.pause_ovf", K_OVF, 16'd1);
      press(1'b1, 1'b0);
      rc += 6;
      step(4);
      sb_push("t3.clr_cnt", K_COUNT, 16'h0000);
      sb_push("t3.clr_ovf", K_OVF, 16'd0);
      press(1'b0, 1'b1);
      rc = 0;
      step(4);

      // Reset asserted mid-RUN
      sb_push("rr.start_run", K_RUN, 16'd1);
      press(1'b1, 1'b0);
      step(9);
      rst = 1'b1;
      #1;
      push_reset_state("rr");
      sb_drain();
      step(2);
      rst = 1'b0;
      step(1);
      sb_push("rr.first_dig", K_DIG, 16'h0001);
      sb_push("rr.first_seg", K_SEG, 16'h003F);
      sb_drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/clear controller for the 4-digit BCD stopwatch counter and its multiplexed 7-segment display. It debounces two raw buttons, sequences a tick prescaler and a BCD counter through an IDLE/RUN/PAUSE state machine, and time-multiplexes the four digits onto one shared segment bus. It sits between the board pins and the seg7 decoder and digit-enable lines.

Parameters:
CLK_DIV, 1000000, clk cycles per count tick; must be >= 2.
SCAN_DIV, 1000, clk cycles each digit is displayed; must be >= 1.
DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required before the debounced level changes.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_start_stop  input  1  raw, asynchronous; active-high start/stop button
btn_clear  input  1  raw, asynchronous; active-high clear button
seg  output  7  active-high segments; seg[0]=a ... seg[6]=g; registered
dig_en  output  4  one-hot active-high digit enable; dig_en[0]=least-significant digit; registered
count_bcd  output  16  four BCD digits; [3:0]=least significant
running  output  1  high in RUN
overflow  output  1  sticky flag, set on wrap from 9999 to 0000

Behaviour:
- Reset (async assert, sync release): state=IDLE; count_bcd=0; prescaler=0; scan counter=0; digit index=0; overflow=0; seg=0; dig_en=0; debouncers=0.
- Input path: each button has a 2-FF synchronizer followed by a debouncer. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples. A press pulse lasts 1 cycle on each debounced 0->1 edge. Latency from raw edge to press pulse is 2+DEBOUNCE_CYCLES cycles (±1).
- FSM transitions (evaluated on the press pulse cycle; the new state is visible the next cycle):
  - IDLE: ss -> RUN, with prescaler cleared to 0. clr -> stays IDLE, count and overflow cleared.
  - RUN: ss -> PAUSE. clr is ignored.
  - PAUSE: clr -> IDLE, count, prescaler and overflow cleared. ss -> RUN; the prescaler resumes from its held value.
  - ss and clr pulse in the same cycle: clr wins in IDLE/PAUSE; ss wins in RUN.
- Prescaler:
  - Counts only in RUN, over 0..CLK_DIV-1. tick = (state==RUN && prescaler==CLK_DIV-1).
  - The prescaler wraps to 0 on tick.
  - It holds its value in PAUSE.
- BCD counter:
  - On the edge where tick=1, the count increments in BCD with per-digit carry.
  - 9999 -> 0000, and overflow is set in the same cycle.
  - No increment outside RUN.
- running = (state==RUN), driven combinationally from the state register.
- Display scan:
  - The scan counter is free-running in all states, over 0..SCAN_DIV-1.
  - On its wrap, the digit index advances 0->1->2->3->0.
  - Registered outputs: dig_en = onehot(index); seg = decode(count_bcd digit[index]).
  - Outputs are updated one cycle after the index/count change, so the first valid display appears in the cycle after reset release.
  - Decode table, 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F. Non-BCD values show 00; they are unreachable.
- Reset asserted mid-RUN: all state returns to reset values immediately.

Decomposition:
- Package stopwatch_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, PAUSE=2'd2;
  - the 10-entry segment lookup constants;
  - the digit count constant (4).
- Sub-module btn_debounce: synchronizer, debounce counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES. It is instantiated twice.

Test Plan (CLK_DIV=4, SCAN_DIV=2, DEBOUNCE_CYCLES=3):
1. Reset, then hold ss high for 10 cycles -> running rises exactly 1 cycle after the press pulse; count_bcd=0x0001 four cycles after RUN entry; a further 4 cycles gives 0x0002.
2. Run, press ss (pause), wait 40 cycles, press ss again -> count is frozen during PAUSE. The first post-resume tick occurs after CLK_DIV minus the held prescaler value.
3. Preload near wrap by running ~40000 cycles, or force count to 0x9999 in RUN -> the next tick gives 0x0000 and overflow=1. Overflow stays 1 until clr in PAUSE/IDLE.
4. Press clr in RUN -> ignored, counting continues. Press clr in PAUSE -> state IDLE, count 0, overflow 0.
5. ss and clr pulse in the same cycle, in PAUSE -> IDLE and cleared; in RUN -> PAUSE and count kept.
6. Display scan with count=0x1234 -> dig_en cycles 0001,0010,0100,1000, each for 2 cycles. seg shows 66,4F,5B,06 in step with dig_en. A 2-cycle glitch on btn_start_stop produces no press pulse.
